// File: rtl/serial_add_pkg.sv
// Shared types and constants for the byte-serial add/subtract sequencer.
package serial_add_pkg;

  localparam int SLICE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  // Number of slice passes for one operation.
  function automatic int slices(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/serial_add32_ctrl_if.sv
// Operand/result valid-ready bus of serial_add32_ctrl.
// out_ovf and its modport entries exist only when SERIAL_ADD_OVF_EN is defined.
interface serial_add32_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             in_sub;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
`ifdef SERIAL_ADD_OVF_EN
  logic             out_ovf;

  modport master (
    output in_valid, in_sub, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_sub, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
`else
  modport master (
    output in_valid, in_sub, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, out_cout
  );

  modport slave (
    input  in_valid, in_sub, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, out_cout
  );
`endif

endinterface

// File: rtl/serial_add32_ctrl_adder_8.sv
// 8-bit carry-lookahead adder slice (adder_8): every carry is expanded
// directly from the generate/propagate terms instead of rippling.
module adder_8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;
  logic       prop;

  assign g = a & b;
  assign p = a ^ b;

  // NOTE: combinational blocks use blocking '=' so later statements see the
  // updated value; sequential blocks use '<=' so all flops update together.
  always_comb begin
    c    = '0;
    prop = 1'b1;
    c[0] = cin;
    for (int i = 1; i <= 8; i++) begin
      prop = 1'b1;
      for (int j = i - 1; j >= 0; j--) begin
        c[i] = c[i] | (prop & g[j]);
        prop = prop & p[j];
      end
      c[i] = c[i] | (prop & cin);
    end
  end

  assign sum  = p ^ c[7:0];
  assign cout = c[8];

endmodule

// File: rtl/serial_add32_ctrl.sv
// Byte-serial WIDTH-bit add/subtract: one shared adder_8 slice, carry rippled
// through a register. Signed overflow output enabled by SERIAL_ADD_OVF_EN.
module serial_add32_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_add32_ctrl_if.slave  bus
);

  localparam int NS    = slices(WIDTH);
  localparam int IDX_W = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NS - 1);

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic               carry;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;
  logic               in_ready_q;
  logic               out_valid_q;

  logic [SLICE_W-1:0] a_byte;
  logic [SLICE_W-1:0] b_byte;
  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout;

  // NOTE: every variable driven here gets a default first, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    a_byte = '0;
    b_byte = '0;
    for (int i = 0; i < NS; i++) begin
      if (idx == IDX_W'(i)) begin
        a_byte = a_q[i*SLICE_W +: SLICE_W];
        b_byte = b_q[i*SLICE_W +: SLICE_W];
      end
    end
  end

  adder_8 u_slice (
    .a    (a_byte),
    .b    (b_byte),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

`ifdef SERIAL_ADD_OVF_EN
  logic a_msb_q;
  logic b_msb_q;
  logic ovf_q;

  assign bus.out_ovf = ovf_q;
`endif

  // NOTE: the operand and result registers are plain flops (not a memory
  // array), so they are reset like control state; out_sum must read 0 in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      carry       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.in_a;
            b_q        <= bus.in_sub ? ~bus.in_b : bus.in_b;
            carry      <= bus.in_sub;
            idx        <= '0;
            in_ready_q <= 1'b0;
            state      <= CALC;
`ifdef SERIAL_ADD_OVF_EN
            a_msb_q    <= bus.in_a[WIDTH-1];
            b_msb_q    <= bus.in_sub ? ~bus.in_b[WIDTH-1] : bus.in_b[WIDTH-1];
`endif
          end
        end

        CALC: begin
          for (int i = 0; i < NS; i++) begin
            if (idx == IDX_W'(i)) sum_q[i*SLICE_W +: SLICE_W] <= slice_sum;
          end
          carry <= slice_cout;
          if (idx == LAST_IDX) begin
            cout_q      <= slice_cout;
            out_valid_q <= 1'b1;
            state       <= DONE;
`ifdef SERIAL_ADD_OVF_EN
            // slice_sum[MSB] of the last byte is the result sign bit.
            ovf_q       <= (a_msb_q == b_msb_q) && (slice_sum[SLICE_W-1] != a_msb_q);
`endif
          end else begin
            idx <= idx + 1'b1;
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end

        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = cout_q;

endmodule

// File: doc/serial_add32_ctrl.md
# serial_add32_ctrl

Multi-cycle sequencer that performs a WIDTH-bit add or subtract by driving one shared 8-bit carry-lookahead slice over WIDTH/8 consecutive cycles, rippling the carry through a register between slices. Sits between the ALU issue logic and the result bus. Trades latency for area when a full-width adder is not justified. Operands enter and results leave through valid/ready handshakes.

## Interface
- WIDTH, 32: operand/result width; must be a multiple of 8, minimum 8.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset; one clock; polarity and synchronicity fixed.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept operands.
- in_sub  in  1  0 = a+b, 1 = a−b.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_sum  out  WIDTH  result.
- out_cout  out  1  carry out of MSB; for subtract, 1 = no borrow.
- out_ovf  out  1  signed overflow; present only with the macro in Configuration.

## Operation
- States: IDLE, CALC, DONE. NS = WIDTH/8 slices.
- IDLE: in_ready=1. Accept on in_valid&&in_ready:
  - latch a;
  - latch b, inverted when in_sub=1;
  - carry register = in_sub;
  - slice index = 0;
  - go to CALC.
- CALC: in_ready=0. The 8-bit slice computes byte[idx] of a + b + carry. Each edge:
  - write result byte idx;
  - carry register = slice cout;
  - idx+1.
  - On the edge that writes byte NS−1, go to DONE.
- DONE: out_valid=1; out_sum, out_cout, out_ovf stable. On out_valid&&out_ready, go to IDLE.
- in_valid and operands are ignored outside IDLE. Only one operation is in flight at a time.
- Arithmetic:
  - sum = (a + b' + cin) mod 2^WIDTH, with b' = b or ~b and cin = in_sub.
  - cout = final carry.
  - ovf = (a[MSB]==b'[MSB]) && (sum[MSB]!=a[MSB]).
- Slice index wraps nowhere: it is cleared on accept and counts 0..NS−1 only.
- out_sum, out_cout and out_ovf hold their last values after the result is taken, until the next accept overwrites them.

## Timing
- Reset (async assert, any state): state=IDLE, in_ready=1, out_valid=0, out_sum=0, out_cout=0, out_ovf=0, carry=0, idx=0.
- A reset asserted mid-CALC or in DONE aborts the operation and discards the result.
- Latency: out_valid rises NS clock edges after the accept edge (4 edges for WIDTH=32).
- Result taken on edge T: in_ready=1 after T. Next accept at the earliest on edge T+1. Minimum issue interval is NS+2 cycles.
- out_valid stays high indefinitely while out_ready=0. Outputs must not change while out_valid=1.
- in_ready and out_valid are never high simultaneously.

## Configuration
- SERIAL_ADD_OVF_EN defined:
  - out_ovf port exists;
  - the a[MSB]/b'[MSB] sign bits are captured at accept;
  - ovf is computed on the final CALC edge.
- SERIAL_ADD_OVF_EN undefined:
  - out_ovf port and its sign-bit registers are absent;
  - all other behaviour and timing are identical.

## Structure
- Shared package serial_add_pkg holds:
  - state enum (IDLE, CALC, DONE);
  - SLICE_W = 8;
  - function computing NS from WIDTH.
- One sub-module: the team's existing 8-bit carry-lookahead adder, adder_8, instantiated exactly once.
- Operand byte selection is an idx-indexed mux feeding that slice. Result bytes are written by idx-decoded enables.

## Test plan
- add 0xFFFFFFFF + 0x00000001, out_ready=1 → out_valid 4 edges after accept; sum=0x00000000, cout=1, ovf=0.
- add 0x7FFFFFFF + 0x00000001 → sum=0x80000000, cout=0, ovf=1 (macro on); with the macro off the port is absent and sum/cout are unchanged.
- sub 0x00000005 − 0x00000007 → sum=0xFFFFFFFE, cout=0, ovf=0.
- sub 0x80000000 − 0x00000001 → sum=0x7FFFFFFF, cout=1, ovf=1.
- Backpressure: out_ready=0 for 10 cycles after out_valid → outputs held, in_ready=0 and in_valid pulses ignored. Then out_ready=1 → in_ready=1 on the next cycle, and the following op 0x12345678 + 0x11111111 gives 0x23456789.
- rst_n low during CALC slice 2 → immediately in_ready=1, out_valid=0, out_sum=0. After release, a new add 0x00000010 + 0x00000020 gives 0x00000030.
